// File: rtl/seq_puzzle_pkg.sv
// Shared types and constants for the sequence-entry puzzle controller.
package seq_puzzle_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StShow,
        StEntry,
        StCheck,
        StSolved,
        StFailed
    } state_e;

    localparam logic [7:0] DISP_CMD_SHOW = 8'h10;
    localparam logic [7:0] DISP_CMD_IDLE = 8'h00;

    localparam logic [3:0] CODE_0 = 4'b1110;
    localparam logic [3:0] CODE_1 = 4'b1101;
    localparam logic [3:0] CODE_2 = 4'b1011;
    localparam logic [3:0] CODE_3 = 4'b0111;

    function automatic logic [3:0] idx_to_code(input logic [1:0] idx);
        logic [3:0] code;
        unique case (idx)
            2'd0: code = CODE_0;
            2'd1: code = CODE_1;
            2'd2: code = CODE_2;
            default: code = CODE_3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (mask 16'hB400), synchronous active-high reset to SEED.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] Mask = 16'hB400;

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) begin
            state_d = state_d ^ Mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sequence_puzzle_ctrl.sv
// Sequence-entry puzzle controller: generate, show, collect and grade a four-step code.
// Optional entry timeout is compiled in with SEQ_PUZZLE_TIMEOUT_EN.
module sequence_puzzle_ctrl
    import seq_puzzle_pkg::*;
#(
    parameter int unsigned MAX_STRIKES        = 3,
    parameter int unsigned SHOW_SECS          = 2,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1,
    parameter int unsigned ENTRY_TIMEOUT_SECS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        one_sec,
    input  logic        button_next,
    input  logic [3:0]  sel_code,
    output logic [15:0] sequence_out,
    output logic [7:0]  display,
    output logic        strike,
    output logic [1:0]  strike_count,
    output logic        solved,
    output logic        failed,
    output logic        busy
);

    localparam logic [1:0]  MaxStrikes = 2'(MAX_STRIKES);
    localparam int unsigned ShowW      = (SHOW_SECS > 1) ? $clog2(SHOW_SECS) : 1;
    localparam logic [ShowW-1:0] ShowLast = ShowW'(SHOW_SECS - 1);

    logic [15:0] lfsr;
    logic [7:0]  lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk),
        .reset_i (reset),
        .state_o (lfsr)
    );

    // Only the low byte seeds a sequence.
    assign lfsr_unused = lfsr[15:8];

    state_e           state_q, state_d;
    logic [15:0]      seq_q, seq_d;
    logic [1:0]       step_q, step_d;
    logic             mism_q, mism_d;
    logic [ShowW-1:0] show_cnt_q, show_cnt_d;
    logic [1:0]       strike_cnt_q, strike_cnt_d;
    logic             strike_q, strike_d;
    logic             solved_q, solved_d;
    logic             failed_q, failed_d;
    logic [7:0]       display_q, display_d;
    logic             busy_q, busy_d;

`ifdef SEQ_PUZZLE_TIMEOUT_EN
    localparam int unsigned TmoW = (ENTRY_TIMEOUT_SECS > 1) ? $clog2(ENTRY_TIMEOUT_SECS) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ENTRY_TIMEOUT_SECS - 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic [31:0] tmo_secs_unused;
    assign tmo_secs_unused = 32'(ENTRY_TIMEOUT_SECS);
`endif

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        step_d       = step_q;
        mism_d       = mism_q;
        show_cnt_d   = show_cnt_q;
        strike_cnt_d = strike_cnt_q;
        strike_d     = 1'b0;
        solved_d     = solved_q;
        failed_d     = failed_q;
`ifdef SEQ_PUZZLE_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        unique case (state_q)
            StIdle, StSolved, StFailed: begin
                if (arm) begin
                    strike_cnt_d = '0;
                    solved_d     = 1'b0;
                    failed_d     = 1'b0;
                    state_d      = StGen;
                end
            end
            StGen: begin
                for (int i = 0; i < 4; i++) begin
                    seq_d[4*i +: 4] = idx_to_code(lfsr[2*i +: 2]);
                end
                step_d     = '0;
                mism_d     = 1'b0;
                show_cnt_d = '0;
`ifdef SEQ_PUZZLE_TIMEOUT_EN
                tmo_cnt_d  = '0;
`endif
                state_d    = StShow;
            end
            StShow: begin
                if (one_sec) begin
                    if (show_cnt_q == ShowLast) begin
                        state_d = StEntry;
                    end else begin
                        show_cnt_d = show_cnt_q + 1'b1;
                    end
                end
            end
            StEntry: begin
                // A press wins over a coincident second tick.
                if (button_next) begin
                    mism_d = mism_q | (sel_code != seq_q[{step_q, 2'b00} +: 4]);
`ifdef SEQ_PUZZLE_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (step_q == 2'd3) begin
                        state_d = StCheck;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
`ifdef SEQ_PUZZLE_TIMEOUT_EN
                else if (one_sec) begin
                    if (tmo_cnt_q == TmoLast) begin
                        mism_d  = 1'b1;
                        state_d = StCheck;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
`endif
            end
            StCheck: begin
                if (!mism_q) begin
                    solved_d = 1'b1;
                    state_d  = StSolved;
                end else begin
                    strike_d = 1'b1;
                    if (strike_cnt_q < MaxStrikes) begin
                        strike_cnt_d = strike_cnt_q + 1'b1;
                    end
                    if (strike_cnt_d == MaxStrikes) begin
                        failed_d = 1'b1;
                        state_d  = StFailed;
                    end else begin
                        state_d = StGen;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs follow the state being entered.
        display_d = (state_d == StShow) ? DISP_CMD_SHOW : DISP_CMD_IDLE;
        busy_d    = (state_d == StGen) || (state_d == StShow) ||
                    (state_d == StEntry) || (state_d == StCheck);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            seq_q        <= '0;
            step_q       <= '0;
            mism_q       <= 1'b0;
            show_cnt_q   <= '0;
            strike_cnt_q <= '0;
            strike_q     <= 1'b0;
            solved_q     <= 1'b0;
            failed_q     <= 1'b0;
            display_q    <= DISP_CMD_IDLE;
            busy_q       <= 1'b0;
`ifdef SEQ_PUZZLE_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            step_q       <= step_d;
            mism_q       <= mism_d;
            show_cnt_q   <= show_cnt_d;
            strike_cnt_q <= strike_cnt_d;
            strike_q     <= strike_d;
            solved_q     <= solved_d;
            failed_q     <= failed_d;
            display_q    <= display_d;
            busy_q       <= busy_d;
`ifdef SEQ_PUZZLE_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign sequence_out = seq_q;
    assign display      = display_q;
    assign strike       = strike_q;
    assign strike_count = strike_cnt_q;
    assign solved       = solved_q;
    assign failed       = failed_q;
    assign busy         = busy_q;

endmodule

// File: doc/sequence_puzzle_ctrl.md
# sequence_puzzle_ctrl

Controller for the sequence-entry puzzle on the four-digit seven-segment display. Generates a pseudo-random four-step target sequence and commands the display block to show it for a fixed number of seconds. It then collects the player's four selections (one per `button_next` press), grades the entry, and reports solved, strike or failure to the top-level game FSM.

## Interface
Parameters:
- `MAX_STRIKES`, 3: wrong-entry count that ends the puzzle as failed (1..3).
- `SHOW_SECS`, 2: number of `one_sec` ticks the target is displayed.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR; must be non-zero.
- `ENTRY_TIMEOUT_SECS`, 10: entry timeout in seconds; used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: one-cycle start pulse from the game FSM.
- `one_sec` in 1: one-cycle tick, once per second.
- `button_next` in 1: one-cycle debounced pulse that commits the current selection.
- `sel_code` in 4: one-hot-low code currently selected on the display (1110/1101/1011/0111).
- `sequence_out` out 16: target sequence; nibble k = bits [4k+3:4k] = step k.
- `display` out 8: command to the display block; 8'h10 = show target, 8'h00 = idle.
- `strike` out 1: one-cycle pulse per wrong entry.
- `strike_count` out 2: strikes accumulated since arm.
- `solved` out 1: level, held until `reset` or the next `arm`.
- `failed` out 1: level, held until `reset` or the next `arm`.
- `busy` out 1: high in GEN, SHOW, ENTRY and CHECK.

## Operation
- States: IDLE, GEN, SHOW, ENTRY, CHECK, SOLVED, FAILED.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle regardless of state.
- IDLE: waits for `arm`; on `arm`, clears `strike_count`, `solved` and `failed`, then goes to GEN.
- GEN: latches LFSR[7:0] as four 2-bit indices; index i (bits [2i+1:2i]) selects nibble i.
  - Index decode: 0→1110, 1→1101, 2→1011, 3→0111.
  - Clears the step index and the mismatch flag, then goes to SHOW.
- SHOW: drives `display`=8'h10 and counts `one_sec` ticks.
  - On the tick that makes the count equal `SHOW_SECS`, drives `display`=8'h00 and goes to ENTRY.
- ENTRY: on `button_next`, compares `sel_code` with nibble[step] and ORs any difference into the mismatch flag.
  - step increments 0..3; the press at step 3 goes to CHECK.
- CHECK (one cycle):
  - Mismatch clear: go to SOLVED.
  - Mismatch set: pulse `strike`, increment `strike_count`. If the new count equals `MAX_STRIKES`, go to FAILED; otherwise go to GEN with a fresh sequence.
- SOLVED / FAILED: terminal states. `arm` restarts the puzzle exactly as from IDLE.
- Ignored events:
  - `arm` while `busy`.
  - `button_next` in IDLE, GEN, SHOW, SOLVED and FAILED.
  - `one_sec` outside SHOW (and outside ENTRY when the timeout is enabled).
- Simultaneous `one_sec` and `button_next` in ENTRY: the press is processed.
- `strike_count` saturates at `MAX_STRIKES`; it never wraps.

## Timing
- Reset values: state IDLE, `sequence_out` 16'h0000, `display` 8'h00, `strike` 0, `strike_count` 0, `solved` 0, `failed` 0, `busy` 0, LFSR = `LFSR_SEED`.
- All outputs are registered.
- `arm` sampled at edge N: GEN at N+1. At N+2, state is SHOW, `sequence_out` is valid and `display`=8'h10.
- `sequence_out` is stable from SHOW until the next GEN.
- The 4th `button_next` sampled at edge M: CHECK at M+1. At M+2, `strike`, `solved` or `failed` is visible, together with the updated `strike_count`.
- `strike` is high for exactly one cycle.
- `reset` at any point, including mid-SHOW or mid-ENTRY: all state returns to reset values on the next edge, and no `strike` pulse is emitted.

## Configuration
- `SEQ_PUZZLE_TIMEOUT_EN` defined: ENTRY counts `one_sec` ticks and resets the count on every `button_next`.
  - Reaching `ENTRY_TIMEOUT_SECS` sets the mismatch flag and goes directly to CHECK, i.e. it counts as a strike.
- `SEQ_PUZZLE_TIMEOUT_EN` not defined: ENTRY waits indefinitely. No timeout counter is built and `ENTRY_TIMEOUT_SECS` is unused.

## Structure
- Package `seq_puzzle_pkg` contains:
  - State enum.
  - `DISP_CMD_SHOW` = 8'h10 and `DISP_CMD_IDLE` = 8'h00.
  - `CODE_0..CODE_3` one-hot-low constants.
  - Index-to-code decode function.
- Sub-module `lfsr16`: free-running Galois LFSR, parameterised by seed, with a 16-bit state output. The controller instantiates it once.

## Test plan
- Reset then `arm`, with LFSR state at GEN forced so bits [7:0] = 8'b11_10_01_00 → `sequence_out`=16'h7BDE, `display`=8'h10 for 2 `one_sec` ticks, then 8'h00.
- Correct entry of 1110,1101,1011,0111 on four `button_next` presses → `solved`=1 two cycles after the 4th press; `strike` never asserted; `busy`=0.
- One wrong code at step 2 → single `strike` pulse, `strike_count`=1, return to GEN with new `sequence_out`, SHOW repeats.
- Three consecutive wrong entries with `MAX_STRIKES`=3 → `failed`=1, `strike_count`=3. A further `arm` clears all flags and restarts.
- `reset` asserted mid-ENTRY after 2 presses → next cycle IDLE, all outputs at reset values; `button_next` presses during SHOW have no effect.
- With `SEQ_PUZZLE_TIMEOUT_EN`, `ENTRY_TIMEOUT_SECS`=10: no press for 10 ticks → `strike` pulse, `strike_count`=1, new GEN.
